// File: rtl/shift_merge_decode_pkg.sv
// Shared constants for the EXTR/DEP/DSR shift-merge decoder.
// Instruction fields are numbered MSB-first (bit 0 is the MSB).
package shift_merge_decode_pkg;

    localparam int WORD_W = 24;
    localparam int POS_W  = 5;

    localparam logic [5:0] OP_EXTR = 6'o12;
    localparam logic [5:0] OP_DEP  = 6'o13;
    localparam logic [5:0] OP_DSR  = 6'o14;

    localparam int OP_MSB = 0;
    localparam int OP_LSB = 5;
    localparam int R_MSB  = 6;
    localparam int R_LSB  = 8;
    localparam int P_MSB  = 9;
    localparam int P_LSB  = 13;
    localparam int L_MSB  = 14;
    localparam int L_LSB  = 18;
    localparam int A_BIT  = 19;
    localparam int S_BIT  = 20;
    localparam int OPT_MSB = 21;
    localparam int OPT_LSB = 23;
    localparam int SA_MSB = 19;
    localparam int SA_LSB = 23;

    localparam logic [4:0] LAST_POS = 5'd23;
    localparam logic [4:0] WORD_LEN = 5'd24;

    typedef struct packed {
        logic [4:0] sa;
        logic [4:0] pl;
        logic [4:0] pr;
    } smd_ctrl_t;

endpackage

// File: rtl/shift_merge_decode.sv
// Execute-stage decode of EXTR/DEP/DSR into shift amount and merge bounds.
// Optional range checking (illegal port) is enabled by SMDEC_CHECK_EN.
module shift_merge_decode
    import shift_merge_decode_pkg::*;
#(
    parameter int WORD_W = shift_merge_decode_pkg::WORD_W,
    parameter int POS_W  = shift_merge_decode_pkg::POS_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [0:WORD_W-1] instr,
    input  logic [0:WORD_W-1] saReg,
    output logic [POS_W-1:0]  sa,
    output logic [POS_W-1:0]  pl,
    output logic [POS_W-1:0]  pr
`ifdef SMDEC_CHECK_EN
    ,
    output logic              illegal
`endif
);

    logic [5:0] op;
    logic [4:0] p_fld;
    logic [4:0] l_fld;
    logic [4:0] sa_fld;
    logic       a_bit;
    logic [4:0] p_eff;
    logic [4:0] l_eff;
    logic       is_extr;
    logic       is_dep;
    logic       is_dsr;

    smd_ctrl_t ctrl_d;
    smd_ctrl_t ctrl_q;

    logic unused_bits;
    assign unused_bits = ^{instr[R_MSB:R_LSB], instr[S_BIT],
                           instr[OPT_MSB:OPT_LSB], saReg[0:SA_MSB-1]};

    assign op     = instr[OP_MSB:OP_LSB];
    assign p_fld  = instr[P_MSB:P_LSB];
    assign l_fld  = instr[L_MSB:L_LSB];
    assign a_bit  = instr[A_BIT];
    assign sa_fld = saReg[SA_MSB:SA_LSB];

    assign is_extr = (op == OP_EXTR);
    assign is_dep  = (op == OP_DEP);
    assign is_dsr  = (op == OP_DSR);

    // A selects which field comes from saReg: L for DSR, P otherwise.
    assign p_eff = (a_bit && !is_dsr) ? sa_fld : p_fld;
    assign l_eff = (a_bit && is_dsr) ? sa_fld : l_fld;

    always_comb begin
        ctrl_d = '0;
        unique case (1'b1)
            is_extr: begin
                ctrl_d.sa = LAST_POS - p_eff;
                ctrl_d.pl = WORD_LEN - l_eff;
                ctrl_d.pr = LAST_POS;
            end
            is_dep: begin
                ctrl_d.sa = p_eff + 5'd1;
                ctrl_d.pl = p_eff - l_eff + 5'd1;
                ctrl_d.pr = p_eff;
            end
            is_dsr: begin
                ctrl_d.sa = l_eff;
                ctrl_d.pl = 5'd0;
                ctrl_d.pr = LAST_POS;
            end
            default: ctrl_d = '0;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q <= '0;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    assign sa = ctrl_q.sa;
    assign pl = ctrl_q.pl;
    assign pr = ctrl_q.pr;

`ifdef SMDEC_CHECK_EN
    logic       illegal_d;
    logic       illegal_q;
    logic [5:0] p_plus1;

    assign p_plus1 = {1'b0, p_eff} + 6'd1;

    always_comb begin
        illegal_d = 1'b0;
        if (is_extr || is_dep || is_dsr) begin
            illegal_d = (p_eff > LAST_POS) || (l_eff > WORD_LEN);
            if ((is_extr || is_dep) && (l_eff == 5'd0)) begin
                illegal_d = 1'b1;
            end
            if (is_dep && ({1'b0, l_eff} > p_plus1)) begin
                illegal_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end

    assign illegal = illegal_q;
`endif

endmodule

// File: tb/tb_shift_merge_decode.sv
// Directed and random stimulus for shift_merge_decode with a scoreboard queue.
// Build with +define+SMDEC_CHECK_EN to also check the illegal flag.
module tb_shift_merge_decode;

    typedef struct {
        string tag;
        int    sa;
        int    pl;
        int    pr;
        int    ill;
    } exp_t;

    logic        clock;
    logic        reset_n;
    logic [0:23] instr;
    logic [0:23] saReg;
    logic [4:0]  sa;
    logic [4:0]  pl;
    logic [4:0]  pr;
    logic        illegal;

    int n_checks;
    int n_fail;
    exp_t sb[$];

    shift_merge_decode dut (
        .clock   (clock),
        .reset_n (reset_n),
        .instr   (instr),
        .saReg   (saReg),
        .sa      (sa),
        .pl      (pl),
        .pr      (pr)
`ifdef SMDEC_CHECK_EN
        ,
        .illegal (illegal)
`endif
    );

`ifndef SMDEC_CHECK_EN
    assign illegal = 1'b0;
`endif

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [0:23] mk(input int op, input int p,
                                       input int l, input int a);
        logic [5:0] o6;
        logic [4:0] p5;
        logic [4:0] l5;
        o6 = op[5:0];
        p5 = p[4:0];
        l5 = l[4:0];
        return {o6, 3'b101, p5, l5, a[0], 1'b1, 3'b011};
    endfunction

    // Reference model written directly from the instruction semantics.
    function automatic exp_t model(input string tag, input int op,
                                   input int p, input int l,
                                   input int a, input int sr);
        exp_t e;
        int pe;
        int le;
        e.tag = tag;
        pe = p;
        le = l;
        if (a != 0) begin
            if (op == 'o14) le = sr % 32;
            else pe = sr % 32;
        end
        e.sa = 0; e.pl = 0; e.pr = 0; e.ill = 0;
        if (op == 'o12) begin
            e.sa = (23 - pe + 64) % 32;
            e.pl = (24 - le + 64) % 32;
            e.pr = 23;
        end else if (op == 'o13) begin
            e.sa = (pe + 1) % 32;
            e.pl = (pe - le + 1 + 64) % 32;
            e.pr = pe;
        end else if (op == 'o14) begin
            e.sa = le;
            e.pl = 0;
            e.pr = 23;
        end
        if (op == 'o12 || op == 'o13 || op == 'o14) begin
            if (pe > 23 || le > 24) e.ill = 1;
            if (op != 'o14 && le == 0) e.ill = 1;
            if (op == 'o13 && le > pe + 1) e.ill = 1;
        end
`ifndef SMDEC_CHECK_EN
        e.ill = 0;
`endif
        return e;
    endfunction

    task automatic cmp(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input exp_t e);
        cmp({e.tag, ".sa"}, int'(sa), e.sa);
        cmp({e.tag, ".pl"}, int'(pl), e.pl);
        cmp({e.tag, ".pr"}, int'(pr), e.pr);
`ifdef SMDEC_CHECK_EN
        cmp({e.tag, ".illegal"}, int'(illegal), e.ill);
`endif
    endtask

    task automatic pop_check();
        exp_t e;
        n_checks++;
        assert (sb.size() > 0)
        else begin
            n_fail++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check_all(e);
        end
    endtask

    // Drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input exp_t e, input logic [0:23] ins,
                        input int sr);
        @(negedge clock);
        instr = ins;
        saReg = sr[23:0];
        sb.push_back(e);
        @(posedge clock);
        #1;
        pop_check();
    endtask

    task automatic dstep(input string tag, input int op, input int p,
                         input int l, input int a, input int sr,
                         input int esa, input int epl, input int epr,
                         input int eill);
        exp_t e;
        e.tag = tag;
        e.sa = esa; e.pl = epl; e.pr = epr;
`ifdef SMDEC_CHECK_EN
        e.ill = eill;
`else
        e.ill = (eill != 0) ? 0 : 0;
`endif
        step(e, mk(op, p, l, a), sr);
    endtask

    initial begin
        exp_t z;
        n_checks = 0;
        n_fail = 0;
        z.tag = "reset"; z.sa = 0; z.pl = 0; z.pr = 0; z.ill = 0;
        reset_n = 1'b0;
        instr = mk('o13, 15, 8, 0);
        saReg = '0;
        repeat (2) @(posedge clock);
        #1;
        check_all(z);
        @(negedge clock);
        reset_n = 1'b1;

        dstep("extr_p10_l19", 'o12, 10, 19, 0, 10, 13, 5, 23, 0);
        dstep("extr_l31", 'o12, 10, 31, 0, 12, 13, 25, 23, 1);
        dstep("extr_a_sareg", 'o12, 10, 4, 1, 20, 3, 20, 23, 0);
        dstep("dep_p15_l8", 'o13, 15, 8, 0, 0, 16, 8, 15, 0);
        dstep("dsr_l7", 'o14, 0, 7, 0, 0, 7, 0, 23, 0);
        dstep("dsr_a_sareg5", 'o14, 0, 7, 1, 5, 5, 0, 23, 0);
        dstep("unknown_op", 'o00, 9, 9, 1, 3, 0, 0, 0, 0);
        dstep("extr_l0", 'o12, 0, 0, 0, 0, 23, 24, 23, 1);
        dstep("dep_l_gt_p1", 'o13, 3, 5, 0, 0, 4, 31, 3, 1);
        dstep("dep_p31_wrap", 'o13, 31, 1, 0, 0, 0, 31, 31, 1);
        dstep("dep_p23_l24", 'o13, 23, 24, 0, 0, 24, 0, 23, 0);
        dstep("dsr_l25", 'o14, 0, 25, 0, 0, 25, 0, 23, 1);

        for (int i = 0; i < 40; i++) begin
            int op;
            int p;
            int l;
            int a;
            int sr;
            int k;
            k = $urandom_range(0, 3);
            op = (k == 0) ? 'o12 : (k == 1) ? 'o13 :
                 (k == 2) ? 'o14 : $urandom_range(0, 63);
            p = $urandom_range(0, 31);
            l = $urandom_range(0, 31);
            a = $urandom_range(0, 1);
            sr = $urandom_range(0, 32'hFFFFFF);
            step(model($sformatf("rand%0d", i), op, p, l, a, sr),
                 mk(op, p, l, a), sr);
        end

        // Mid-cycle async reset: outputs clear with no clock edge.
        dstep("pre_reset_dep", 'o13, 15, 8, 0, 0, 16, 8, 15, 0);
        @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        z.tag = "async_reset";
        check_all(z);
        @(posedge clock);
        #1;
        z.tag = "held_reset";
        check_all(z);
        @(negedge clock);
        reset_n = 1'b1;
        dstep("post_reset_dep", 'o13, 15, 8, 0, 0, 16, 8, 15, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
